// File: rtl/tiny_alu_driver.sv
// rtl/tiny_alu_driver.sv - command/response front end for a fixed-latency tiny ALU
// Optional result self-check: TINY_ALU_DRV_CHECK_EN.
module tiny_alu_driver #(
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic             alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_y,
    output logic             rsp_err,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0]       LAT     = 4'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             alu_op_q, alu_op_d;
    logic [3:0]       alu_a_q, alu_a_d;
    logic [3:0]       alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [3:0]       rsp_y_q, rsp_y_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             accept;
    logic             capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            alu_op_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            txn_q       <= txn_d;
        end
    end

    // Operands are only loaded on accept so the ALU sees them stable across WAIT.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        txn_d       = txn_q;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept   = 1'b1;
                    alu_op_d = cmd_op;
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    wcnt_d   = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == LAT) begin
                    capture     = 1'b1;
                    rsp_y_d     = alu_y;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_d       = txn_q + CNT_ONE;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE) && rst_n;
        alu_op    = alu_op_q;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        rsp_valid = rsp_valid_q;
        rsp_y     = rsp_y_q;
        txn_count = txn_q;
    end

`ifdef TINY_ALU_DRV_CHECK_EN
    logic [3:0] exp_q, exp_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (accept) begin
            exp_d = cmd_op ? (cmd_a & cmd_b) : (cmd_a ^ cmd_b);
        end
        if (capture) begin
            err_d = (alu_y != exp_q);
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_hooks;
    assign unused_hooks = accept ^ capture;
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tiny_alu_driver.sv
// tb/tb_tiny_alu_driver.sv - randomized self-checking bench for tiny_alu_driver
module tb_tiny_alu_driver;

    localparam int ALU_LAT = 2;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready, cmd_op;
    logic [3:0]       cmd_a, cmd_b;
    logic             alu_op;
    logic [3:0]       alu_a, alu_b, alu_y;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [3:0]       rsp_y;
    logic [CNT_W-1:0] txn_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int model_cnt = 0;
    bit alu_kill = 1'b0;
    logic [3:0] y_pipe [ALU_LAT];

    tiny_alu_driver #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Neighbouring ALU: result appears ALU_LAT edges after operands settle.
    always @(posedge clk) begin
        y_pipe[0] <= alu_op ? (alu_a & alu_b) : (alu_a ^ alu_b);
        for (int i = 1; i < ALU_LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign alu_y = alu_kill ? 4'h0 : y_pipe[ALU_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_op    = 1'($urandom);
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
    endtask

    task automatic do_txn(input logic op, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input bit kill, input bit chk_gap);
        logic [3:0] ey;
        logic       ee;
        ey = op ? (a & b) : (a ^ b);
        ee = 1'b0;
        if (kill) begin
`ifdef TINY_ALU_DRV_CHECK_EN
            ee = (ey != 4'h0);
`endif
            ey = 4'h0;
        end
        alu_kill = kill;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        rsp_ready = 1'($urandom);
        tick();
        if (chk_gap) check("accept_gap", cyc - last_acc, ALU_LAT + 3);
        last_acc = cyc;
        check("cmd_ready_after_accept", cmd_ready, 0);
        check("alu_op_load", alu_op, op);
        check("alu_a_load", alu_a, a);
        check("alu_b_load", alu_b, b);
        for (int i = 0; i < ALU_LAT; i++) begin
            scramble_cmd();
            rsp_ready = 1'($urandom);
            tick();
            check("rsp_valid_wait", rsp_valid, 0);
            check("cmd_ready_wait", cmd_ready, 0);
            check("alu_op_stable", alu_op, op);
            check("alu_a_stable", alu_a, a);
            check("alu_b_stable", alu_b, b);
        end
        rsp_ready = (hold == 0);
        scramble_cmd();
        tick();
        check("rsp_valid_rise", rsp_valid, 1);
        check("rsp_y", rsp_y, ey);
        check("rsp_err", rsp_err, ee);
        check("txn_count_pre", txn_count, CNT_W'(model_cnt));
        for (int h = 0; h < hold; h++) begin
            scramble_cmd();
            cmd_valid = 1'b1;
            tick();
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_y_hold", rsp_y, ey);
            check("rsp_err_hold", rsp_err, ee);
            check("cmd_ready_hold", cmd_ready, 0);
            check("alu_a_hold", alu_a, a);
        end
        rsp_ready = 1'b1;
        scramble_cmd();
        tick();
        model_cnt++;
        check("rsp_valid_fall", rsp_valid, 0);
        check("txn_count", txn_count, CNT_W'(model_cnt));
        check("cmd_ready_back", cmd_ready, 1);
        check("alu_a_kept", alu_a, a);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        alu_kill  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_txn_count", txn_count, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_txn(1'b0, 4'hA, 4'h6, 0, 1'b0, 1'b0);
        do_txn(1'b1, 4'hC, 4'hA, 0, 1'b0, 1'b1);
        do_txn(1'b0, 4'h3, 4'h9, 5, 1'b0, 1'b0);
        do_txn(1'b0, 4'hF, 4'hF, 0, 1'b0, 1'b0);
        do_txn(1'b1, 4'hF, 4'h3, 0, 1'b0, 1'b1);
        do_txn(1'b0, 4'h0, 4'h5, 0, 1'b0, 1'b1);

        // Reset in the middle of WAIT drops the transaction.
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 4'h7; cmd_b = 4'h9;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_b", alu_b, 0);
        check("midrst_txn_count", txn_count, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postrst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < ALU_LAT + 2; i++) begin
            tick();
            check("postrst_no_rsp", rsp_valid, 0);
        end

        do_txn(1'b0, 4'h3, 4'h5, 0, 1'b1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            do_txn(1'($urandom), 4'($urandom), 4'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tiny_alu_driver.md
Name: tiny_alu_driver

Overview:
Initiator side of the tiny ALU operand/result interface. Accepts one command at a time over a valid/ready port and drives op/a/b to a neighbouring tiny_alu instance. It waits out the ALU's fixed pipeline latency, captures y, and returns the result over a valid/ready response port. It is the front end that lets a CPU-side or bench-side producer use the ALU without knowing its timing.

Parameters:
ALU_LAT, 2, clock edges from operands applied at the ALU until its y output holds the result; legal values 1..15
CNT_W, 8, width of the completed-transaction counter

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  driver can accept a command
cmd_op  in  1  0 = XOR, 1 = AND
cmd_a  in  4  operand A
cmd_b  in  4  operand B
alu_op  out  4->1  registered op to the ALU (1 bit)
alu_a  out  4  registered operand A to the ALU
alu_b  out  4  registered operand B to the ALU
alu_y  in  4  ALU result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes the result
rsp_y  out  4  captured result
rsp_err  out  1  self-check mismatch flag, valid with rsp_valid
txn_count  out  CNT_W  completed response handshakes, wraps

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE, alu_op/alu_a/alu_b = 0, rsp_valid = 0, rsp_y = 0, rsp_err = 0, txn_count = 0, wait counter = 0.
  - cmd_ready = 0 while rst_n is low.
- cmd_ready = (state == IDLE) && rst_n. It is combinational from state; it never depends on cmd_valid.
- IDLE:
  - On an edge with cmd_valid && cmd_ready: register cmd_op/a/b into alu_op/a/b, clear the counter, go to WAIT.
  - Otherwise remain in IDLE.
- WAIT:
  - alu_op/a/b stay stable for the whole of WAIT. The ALU samples op at its output edge, so op must not change early.
  - The counter increments each edge.
  - On the edge where counter == ALU_LAT: capture alu_y into rsp_y, set rsp_valid = 1, go to RESP.
  - This puts rsp_valid high ALU_LAT+1 edges after the accepting edge. With the default, accept at edge E0 gives rsp_valid high after E3.
- RESP:
  - rsp_valid = 1; rsp_y and rsp_err are held stable while rsp_ready is low. Backpressure is unbounded.
  - On an edge with rsp_ready high: rsp_valid = 0, txn_count += 1 (wraps at 2^CNT_W), go to IDLE.
- alu_op/a/b keep their last values after the response until the next accept. They are not cleared.
- No new command is accepted in WAIT or RESP. Minimum period per transaction = ALU_LAT+3 cycles: accept, ALU_LAT+1 wait edges, response handshake.
- cmd_valid is ignored outside IDLE; there is no buffering. A producer holding cmd_valid high gets accepted on its first IDLE cycle.
- rsp_ready high while rsp_valid is low has no effect.
- Reset asserted mid-WAIT or mid-RESP: the in-flight transaction is dropped, no response is produced, and txn_count returns to 0.

Optional Feature:
Macro TINY_ALU_DRV_CHECK_EN.
- Defined:
  - At accept, the expected result is registered: cmd_op ? (cmd_a & cmd_b) : (cmd_a ^ cmd_b).
  - At capture, rsp_err = (alu_y != expected). rsp_err is held with rsp_y through RESP.
  - Reset value of the expected register is 0.
- Not defined: no expected register is built and rsp_err is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset release, then cmd op=0 a=4'hA b=4'h6 with rsp_ready=1 -> rsp_valid high exactly 3 edges after accept, rsp_y=4'hC, rsp_err=0, txn_count=1.
- cmd op=1 a=4'hC b=4'hA -> rsp_y=4'h8. alu_op stays 1 throughout WAIT; cmd_ready=0 from the accept edge until the response handshake.
- Hold rsp_ready=0 for 5 cycles after rsp_valid rises, change cmd_* meanwhile -> rsp_y/rsp_valid stable, no second accept; on rsp_ready=1, txn_count increments and cmd_ready returns the next cycle.
- cmd_valid held high with 3 queued commands (XOR F^F, AND F&3, XOR 0^5) -> responses 0, 3, 5 in order, one accept per 5 cycles, txn_count=3.
- Drop rst_n for 1 cycle during WAIT (counter=1) -> rsp_valid stays 0, alu_a/alu_b/alu_op=0, txn_count=0, cmd_ready=1 after release.
- With TINY_ALU_DRV_CHECK_EN defined, force alu_y to 4'h0 for cmd op=0 a=3 b=5 -> rsp_y=0, rsp_err=1; without the macro, rsp_err=0.
